// File: rtl/hazard_sched_if.sv
// hazard_sched_if: decode-side flags, redirect, data-memory handshake and the
// hazard/forwarding controls that come back from the scheduler.
//   slave  : the scheduler side (decoder flags and memory handshake in, controls out)
//   master : the core/bench side (drives decoder flags and memory handshake)
// Parameter RA_W sets the register address width and must match the scheduler's RA_W.
interface hazard_sched_if #(parameter int RA_W = 5);
  logic            id_valid;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic            id_use_rs1, id_use_rs2;
  logic            id_regwrite, id_memread, id_memwrite;
  logic            ex_redirect;
  logic            mem_req_ready, mem_resp_valid;
  logic            if_stall, id_flush, ex_bubble, mem_stall;
  logic [1:0]      ex_fwd_a, ex_fwd_b;
  logic            mem_req_valid, mem_err;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_regwrite, id_memread, id_memwrite, ex_redirect,
           mem_req_ready, mem_resp_valid,
    output if_stall, id_flush, ex_bubble, mem_stall, ex_fwd_a, ex_fwd_b,
           mem_req_valid, mem_err
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_regwrite, id_memread, id_memwrite, ex_redirect,
           mem_req_ready, mem_resp_valid,
    input  if_stall, id_flush, ex_bubble, mem_stall, ex_fwd_a, ex_fwd_b,
           mem_req_valid, mem_err
  );
endinterface

// File: rtl/hazard_sched.sv
// hazard_sched: pipeline sequencer for a 5-stage RV32I core.
// Tracks the instructions in EX and MEM, produces load-use stalls, redirect
// flushes, ID/EX bubbles and EX operand forwarding selects, and runs the
// multi-cycle data-memory handshake with a watchdog abort.
// Ports:
//   clock  - core clock, all state on rising edge
//   reset  - synchronous, active-low
//   bus    - hazard_sched_if.slave (decoder flags, redirect, memory handshake in;
//            if_stall/id_flush/ex_bubble/mem_stall/ex_fwd_a/b/mem_req_valid/mem_err out)
// Optional build: define HAZARD_SCHED_PERF_EN to add perf_stall_cnt and
// perf_flush_cnt (PERF_W bits, wrapping, cleared on reset).
module hazard_sched #(
  parameter int RA_W        = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input logic clock,
  input logic reset,
  hazard_sched_if.slave bus
`ifdef HAZARD_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mstate_e;

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            ld;
    logic            st;
  } stg_t;

  // WB needs no tracking: forwarding is resolved in ID, where a producer still
  // sitting in MEM becomes the WB-stage source once the consumer reaches EX.
  stg_t            ex_q, ex_d, mem_q, mem_d;
  mstate_e         state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic mem_op, abort, mem_stall, lu_hit, redir, lu_stall;

  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [RA_W-1:0] rs,
                                         input stg_t ex, input stg_t mem, input logic drop);
    if (!use_rs)                                      return 2'b00;
    if (ex.v && ex.wr && ex.rd != '0 && ex.rd == rs)  return 2'b01;
    // an aborted op retires without writing, so it is no forwarding source
    if (mem.v && mem.wr && !drop && mem.rd != '0 && mem.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    mem_op    = mem_q.v && (mem_q.ld || mem_q.st);
    // abort lands on the MEM_TIMEOUT-th cycle spent in REQ|WAIT
    abort     = (state_q != IDLE) && (wdog_q == WD_W'(MEM_TIMEOUT - 1));
    mem_stall = mem_op && !(state_q == WAIT && bus.mem_resp_valid) && !abort;
    lu_hit    = bus.id_valid && ex_q.v && ex_q.ld && ex_q.rd != '0 &&
                ((bus.id_use_rs1 && bus.id_rs1 == ex_q.rd) ||
                 (bus.id_use_rs2 && bus.id_rs2 == ex_q.rd));
    redir     = !mem_stall && bus.ex_redirect;
    lu_stall  = !mem_stall && !bus.ex_redirect && lu_hit;
  end

  assign bus.mem_stall     = mem_stall;
  assign bus.id_flush      = redir;
  assign bus.ex_bubble     = redir || lu_stall;
  assign bus.if_stall      = lu_stall;
  assign bus.ex_fwd_a      = fwd_a_q;
  assign bus.ex_fwd_b      = fwd_b_q;
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_err       = abort;

  // stage tracking and forwarding selects
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!mem_stall) begin
      mem_d   = ex_q;
      ex_d    = '0;
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      if (bus.id_valid && !(redir || lu_stall)) begin
        ex_d    = '{v: 1'b1, rd: bus.id_rd, wr: bus.id_regwrite,
                    ld: bus.id_memread, st: bus.id_memwrite};
        fwd_a_d = fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_q, mem_q, abort);
        fwd_b_d = fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_q, mem_q, abort);
      end
    end
  end

  // memory FSM and watchdog
  always_comb begin
    state_d = state_q;
    wdog_d  = '0;
    if (!mem_stall) begin
      // an op entering MEM starts its request at once (WAIT -> REQ back to back);
      // after an abort the FSM rests in IDLE and picks up a waiting op next cycle
      state_d = (!abort && ex_q.v && (ex_q.ld || ex_q.st)) ? REQ : IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     if (bus.mem_req_ready) state_d = WAIT;
        WAIT:    state_d = WAIT;
        default: state_d = IDLE;
      endcase
      if (state_q != IDLE) wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      state_q <= IDLE;
      wdog_q  <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      state_q <= state_d;
      wdog_q  <= wdog_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

`ifdef HAZARD_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + PERF_W'(lu_stall || mem_stall);
    perf_flush_d = perf_flush_q + PERF_W'(redir);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;
  localparam int RA_W   = 5;
  localparam int TMO    = 6;
  localparam int PERF_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hazard_sched_if #(.RA_W(RA_W)) bus ();

`ifdef HAZARD_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_sched #(.RA_W(RA_W), .MEM_TIMEOUT(TMO), .PERF_W(PERF_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef HAZARD_SCHED_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instructions are records; memory progress is "phase" (0 none, 1 request
  // outstanding, 2 granted, awaiting data) plus how many cycles it has taken.
  typedef struct {
    bit v;
    int rd;
    bit wr, ld, st;
  } ins_t;

  ins_t m_ex, m_mem;
  int   m_phase, m_age, m_fa, m_fb;
  logic [PERF_W-1:0] m_pstall, m_pflush;

  function automatic void model_reset();
    m_ex = '{0, 0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0, 0};
    m_phase = 0; m_age = 0; m_fa = 0; m_fb = 0;
    m_pstall = '0; m_pflush = '0;
  endfunction

  // youngest producer wins; x0 never forwarded; unused source reads the regfile
  function automatic int src(bit use_rs, int rs, bit mem_dropped);
    if (!use_rs) return 0;
    if (m_ex.v && m_ex.wr && m_ex.rd != 0 && m_ex.rd == rs) return 1;
    if (m_mem.v && m_mem.wr && !mem_dropped && m_mem.rd != 0 && m_mem.rd == rs) return 2;
    return 0;
  endfunction

  // One clock cycle: inputs are already driven; check outputs, advance model.
  task automatic cycle();
    bit mop, ab, fin, busy, lu, red, lus;
    int rs1, rs2;
    ins_t nw;
    #1;
    rs1  = int'(bus.id_rs1);
    rs2  = int'(bus.id_rs2);
    mop  = m_mem.v && (m_mem.ld || m_mem.st);
    ab   = (m_phase != 0) && (m_age + 1 >= TMO);
    fin  = (m_phase == 2) && bus.mem_resp_valid;
    busy = mop && !fin && !ab;
    lu   = bus.id_valid && m_ex.v && m_ex.ld && m_ex.rd != 0 &&
           ((bus.id_use_rs1 && rs1 == m_ex.rd) || (bus.id_use_rs2 && rs2 == m_ex.rd));
    red  = !busy && bus.ex_redirect;
    lus  = !busy && !bus.ex_redirect && lu;

    chk("if_stall",  32'(bus.if_stall),      32'(lus));
    chk("id_flush",  32'(bus.id_flush),      32'(red));
    chk("ex_bubble", 32'(bus.ex_bubble),     32'(red || lus));
    chk("mem_stall", 32'(bus.mem_stall),     32'(busy));
    chk("fwd_a",     32'(bus.ex_fwd_a),      32'(m_fa));
    chk("fwd_b",     32'(bus.ex_fwd_b),      32'(m_fb));
    chk("mem_req",   32'(bus.mem_req_valid), 32'(m_phase == 1));
    chk("mem_err",   32'(bus.mem_err),       32'(ab));
`ifdef HAZARD_SCHED_PERF_EN
    chk("perf_stall", 32'(perf_stall_cnt), 32'(m_pstall));
    chk("perf_flush", 32'(perf_flush_cnt), 32'(m_pflush));
`endif

    if (!reset) begin
      model_reset();
    end else begin
      if (lus || busy) m_pstall = m_pstall + 1'b1;
      if (red)         m_pflush = m_pflush + 1'b1;
      if (!busy) begin
        nw = '{0, 0, 0, 0, 0};
        m_fa = 0; m_fb = 0;
        if (bus.id_valid && !(red || lus)) begin
          nw = '{1, int'(bus.id_rd), bus.id_regwrite, bus.id_memread, bus.id_memwrite};
          m_fa = src(bus.id_use_rs1, rs1, ab);
          m_fb = src(bus.id_use_rs2, rs2, ab);
        end
        m_mem = m_ex;
        m_ex  = nw;
        m_age = 0;
        m_phase = (!ab && m_mem.v && (m_mem.ld || m_mem.st)) ? 1 : 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else begin
        m_age++;
        if (m_phase == 1 && bus.mem_req_ready) m_phase = 2;
      end
    end
    @(negedge clock);
  endtask

  task automatic drive_idle();
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_regwrite = 0;
    bus.id_memread = 0; bus.id_memwrite = 0; bus.ex_redirect = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
  endtask

  // Small register range makes hazards frequent; pct sets memory responsiveness.
  task automatic drive_rand(input int pct);
    int kind;
    bus.id_valid   = ($urandom_range(0, 99) < 85);
    bus.id_rs1     = RA_W'($urandom_range(0, 3));
    bus.id_rs2     = RA_W'($urandom_range(0, 3));
    bus.id_rd      = RA_W'($urandom_range(0, 3));
    bus.id_use_rs1 = ($urandom_range(0, 99) < 80);
    bus.id_use_rs2 = ($urandom_range(0, 99) < 60);
    kind = $urandom_range(0, 5);
    bus.id_memread  = (kind < 2);
    bus.id_memwrite = (kind == 2);
    bus.id_regwrite = (kind < 2) || (kind > 2 && $urandom_range(0, 3) != 0);
    bus.ex_redirect    = ($urandom_range(0, 7) == 0);
    bus.mem_req_ready  = ($urandom_range(0, 99) < pct);
    bus.mem_resp_valid = ($urandom_range(0, 99) < pct);
  endtask

  initial begin
    bit reached;
    drive_idle();
    model_reset();
    reset = 0;
    @(negedge clock);
    @(negedge clock);
    cycle();            // still in reset: everything must read 0
    reset = 1;

    for (int i = 0; i < 3000; i++) begin
      drive_rand(((i / 100) % 2 == 0) ? 50 : 4);
      cycle();
    end

    // push loads through with an instant grant but no data until WAIT is reached
    reached = 0;
    for (int i = 0; i < 500 && !reached; i++) begin
      if (m_phase == 2) begin
        reached = 1;
      end else begin
        drive_rand(0);
        bus.id_memread = 1; bus.id_memwrite = 0; bus.ex_redirect = 0;
        bus.mem_req_ready = 1;
        cycle();
      end
    end
    chk("reach_wait", 32'(reached), 32'(1));

    // reset sampled mid-access, then everything (incl. request) must be gone
    drive_idle();
    reset = 0;
    cycle();
    reset = 1;
    cycle();
    chk("rst_req_drop", 32'(bus.mem_req_valid), 32'(0));

    for (int i = 0; i < 300; i++) begin
      drive_rand(30);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
